// File: rtl/perceptron_backprop.sv
// rtl/perceptron_backprop.sv - perceptron backward pass: delta, back-propagated error and weight update on one shared multiplier
// Optional macro PERCEPTRON_BP_SAT_EN: saturate fixmul results and weight subtractions instead of wrapping.
module perceptron_backprop #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_w0_init,
  input  logic [WIDTH-1:0] i_w1_init,
  input  logic [WIDTH-1:0] i_bias_init,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_k0,
  input  logic [WIDTH-1:0] i_k1,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_delta_in,
  input  logic [WIDTH-1:0] i_lr,
  output logic [WIDTH-1:0] o_w0,
  output logic [WIDTH-1:0] o_w1,
  output logic [WIDTH-1:0] o_bias,
  output logic [WIDTH-1:0] o_delta_k0,
  output logic [WIDTH-1:0] o_delta_k1,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_DER, S_DEL, S_PB0, S_PB1, S_G0, S_U0, S_G1, S_U1, S_UB, S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
`ifdef PERCEPTRON_BP_SAT_EN
  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] k0_q, k0_d, k1_q, k1_d, a_q, a_d, din_q, din_d, lr_q, lr_d;
  logic [WIDTH-1:0] tmp_q, tmp_d, delta_q, delta_d;
  logic [WIDTH-1:0] w0_q, w0_d, w1_q, w1_d, bias_q, bias_d;
  logic [WIDTH-1:0] dk0_q, dk0_d, dk1_q, dk1_d;
  logic             done_q, done_d;

  logic signed [WIDTH-1:0]   mul_x, mul_y;
  logic signed [2*WIDTH-1:0] prod, prod_sh;
  logic [WIDTH-1:0]          mul_r;
  logic [WIDTH-1:0]          sub_a, sub_r;
  logic [WIDTH:0]            sub_full;

  // Shared multiplier: floor shift, then either saturate or keep the low word.
  always_comb begin
    prod    = mul_x * mul_y;
    prod_sh = prod >>> FRAC;
`ifdef PERCEPTRON_BP_SAT_EN
    if ((&prod_sh[2*WIDTH-1:WIDTH-1]) || !(|prod_sh[2*WIDTH-1:WIDTH-1])) begin
      mul_r = prod_sh[WIDTH-1:0];
    end else begin
      mul_r = prod_sh[2*WIDTH-1] ? MIN_V : MAX_V;
    end
`else
    mul_r = WIDTH'(prod_sh);
`endif
  end

  always_comb begin
    sub_full = {sub_a[WIDTH-1], sub_a} - {mul_r[WIDTH-1], mul_r};
`ifdef PERCEPTRON_BP_SAT_EN
    if (sub_full[WIDTH] != sub_full[WIDTH-1]) begin
      sub_r = sub_full[WIDTH] ? MIN_V : MAX_V;
    end else begin
      sub_r = sub_full[WIDTH-1:0];
    end
`else
    sub_r = WIDTH'(sub_full);
`endif
  end

  always_comb begin
    state_d = state_q;
    k0_d    = k0_q;
    k1_d    = k1_q;
    a_d     = a_q;
    din_d   = din_q;
    lr_d    = lr_q;
    tmp_d   = tmp_q;
    delta_d = delta_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    bias_d  = bias_q;
    dk0_d   = dk0_q;
    dk1_d   = dk1_q;
    done_d  = (state_q == S_DONE);
    mul_x   = '0;
    mul_y   = '0;
    sub_a   = w0_q;
    case (state_q)
      S_IDLE: begin
        if (i_load) begin
          w0_d   = i_w0_init;
          w1_d   = i_w1_init;
          bias_d = i_bias_init;
        end else if (i_start) begin
          k0_d    = i_k0;
          k1_d    = i_k1;
          a_d     = i_a;
          din_d   = i_delta_in;
          lr_d    = i_lr;
          state_d = S_DER;
        end
      end
      S_DER: begin
        mul_x   = a_q;
        mul_y   = ONE - a_q;
        tmp_d   = mul_r;
        state_d = S_DEL;
      end
      S_DEL: begin
        mul_x   = din_q;
        mul_y   = tmp_q;
        delta_d = mul_r;
        state_d = S_PB0;
      end
      S_PB0: begin
        mul_x   = delta_q;
        mul_y   = w0_q;
        dk0_d   = mul_r;
        state_d = S_PB1;
      end
      S_PB1: begin
        mul_x   = delta_q;
        mul_y   = w1_q;
        dk1_d   = mul_r;
        state_d = S_G0;
      end
      S_G0: begin
        mul_x   = delta_q;
        mul_y   = k0_q;
        tmp_d   = mul_r;
        state_d = S_U0;
      end
      S_U0: begin
        mul_x   = lr_q;
        mul_y   = tmp_q;
        sub_a   = w0_q;
        w0_d    = sub_r;
        state_d = S_G1;
      end
      S_G1: begin
        mul_x   = delta_q;
        mul_y   = k1_q;
        tmp_d   = mul_r;
        state_d = S_U1;
      end
      S_U1: begin
        mul_x   = lr_q;
        mul_y   = tmp_q;
        sub_a   = w1_q;
        w1_d    = sub_r;
        state_d = S_UB;
      end
      S_UB: begin
        mul_x   = lr_q;
        mul_y   = delta_q;
        sub_a   = bias_q;
        bias_d  = sub_r;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k0_q    <= '0;
      k1_q    <= '0;
      a_q     <= '0;
      din_q   <= '0;
      lr_q    <= '0;
      tmp_q   <= '0;
      delta_q <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
      bias_q  <= '0;
      dk0_q   <= '0;
      dk1_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k0_q    <= k0_d;
      k1_q    <= k1_d;
      a_q     <= a_d;
      din_q   <= din_d;
      lr_q    <= lr_d;
      tmp_q   <= tmp_d;
      delta_q <= delta_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      bias_q  <= bias_d;
      dk0_q   <= dk0_d;
      dk1_q   <= dk1_d;
      done_q  <= done_d;
    end
  end

  // The done pulse trails the DONE state by one cycle, so busy covers it too.
  assign o_busy     = (state_q != S_IDLE) || done_q;
  assign o_done     = done_q;
  assign o_w0       = w0_q;
  assign o_w1       = w1_q;
  assign o_bias     = bias_q;
  assign o_delta_k0 = dk0_q;
  assign o_delta_k1 = dk1_q;

endmodule

// File: tb/tb_perceptron_backprop.sv
// tb/tb_perceptron_backprop.sv - self-checking bench for perceptron_backprop against an arithmetic reference model
module tb_perceptron_backprop;

  localparam int          F   = 24;
  localparam logic [31:0] ONE = 32'h0100_0000;
  localparam logic [31:0] HLF = 32'h0080_0000;

  logic        clk = 1'b0;
  logic        rst_n, i_load, i_start;
  logic [31:0] i_w0_init, i_w1_init, i_bias_init;
  logic [31:0] i_k0, i_k1, i_a, i_delta_in, i_lr;
  logic [31:0] o_w0, o_w1, o_bias, o_delta_k0, o_delta_k1;
  logic        o_busy, o_done;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] m_w0 = '0, m_w1 = '0, m_b = '0, m_dk0 = '0, m_dk1 = '0;

  always #5 clk = ~clk;

  perceptron_backprop dut (
    .clk(clk), .rst_n(rst_n), .i_load(i_load),
    .i_w0_init(i_w0_init), .i_w1_init(i_w1_init), .i_bias_init(i_bias_init),
    .i_start(i_start), .i_k0(i_k0), .i_k1(i_k1), .i_a(i_a),
    .i_delta_in(i_delta_in), .i_lr(i_lr),
    .o_w0(o_w0), .o_w1(o_w1), .o_bias(o_bias),
    .o_delta_k0(o_delta_k0), .o_delta_k1(o_delta_k1),
    .o_busy(o_busy), .o_done(o_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] clip(input longint v);
    longint r;
    r = v;
`ifdef PERCEPTRON_BP_SAT_EN
    if (r > 64'sd2147483647) r = 64'sd2147483647;
    if (r < -64'sd2147483648) r = -64'sd2147483648;
`endif
    return r[31:0];
  endfunction

  function automatic logic [31:0] fm(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return clip(p >>> F);
  endfunction

  function automatic logic [31:0] fsub(input logic [31:0] w, input logic [31:0] u);
    return clip(longint'($signed(w)) - longint'($signed(u)));
  endfunction

  task automatic model_step(input logic [31:0] k0, k1, a, din, lr,
                            output logic [31:0] nw0, nw1, nb, ndk0, ndk1);
    logic [31:0] d, dl;
    d    = fm(a, ONE - a);
    dl   = fm(din, d);
    ndk0 = fm(dl, m_w0);
    ndk1 = fm(dl, m_w1);
    nw0  = fsub(m_w0, fm(lr, fm(dl, k0)));
    nw1  = fsub(m_w1, fm(lr, fm(dl, k1)));
    nb   = fsub(m_b, fm(lr, dl));
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_w0"},   o_w0,       m_w0);
    check({tag, "_w1"},   o_w1,       m_w1);
    check({tag, "_bias"}, o_bias,     m_b);
    check({tag, "_dk0"},  o_delta_k0, m_dk0);
    check({tag, "_dk1"},  o_delta_k1, m_dk1);
  endtask

  task automatic do_load(input logic [31:0] w0, w1, b);
    @(negedge clk);
    i_load = 1'b1; i_w0_init = w0; i_w1_init = w1; i_bias_init = b;
    @(negedge clk);
    i_load = 1'b0;
    m_w0 = w0; m_w1 = w1; m_b = b;
    check("load_w0", o_w0, m_w0);
    check("load_w1", o_w1, m_w1);
    check("load_bias", o_bias, m_b);
  endtask

  // Drives one step and checks every output on the negedge after edges E0..E11.
  task automatic run_step(input logic [31:0] k0, k1, a, din, lr,
                          input int reset_at, input bit mid_load, input bit hold);
    logic [31:0] nw0, nw1, nb, ndk0, ndk1;
    model_step(k0, k1, a, din, lr, nw0, nw1, nb, ndk0, ndk1);
    @(negedge clk);
    i_start = 1'b1; i_k0 = k0; i_k1 = k1; i_a = a; i_delta_in = din; i_lr = lr;
    for (int n = 0; n <= 11; n++) begin
      @(negedge clk);
      if (n == 0 && !hold) begin
        i_start = 1'b0;
        i_k0 = $urandom; i_k1 = $urandom; i_a = $urandom; i_delta_in = $urandom; i_lr = $urandom;
      end
      if (n == reset_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        m_w0 = '0; m_w1 = '0; m_b = '0; m_dk0 = '0; m_dk1 = '0;
        check_outputs("midrst");
        check("midrst_busy", {31'b0, o_busy}, 32'd0);
        check("midrst_done", {31'b0, o_done}, 32'd0);
        rst_n = 1'b1;
        return;
      end
      if (mid_load) begin
        i_load = (n == 3);
        i_w0_init = $urandom; i_w1_init = $urandom; i_bias_init = $urandom;
      end
      check("busy", {31'b0, o_busy}, {31'b0, (n <= 10) || hold});
      check("done", {31'b0, o_done}, {31'b0, n == 10});
      check("w0",   o_w0,       (n >= 6) ? nw0 : m_w0);
      check("w1",   o_w1,       (n >= 8) ? nw1 : m_w1);
      check("bias", o_bias,     (n >= 9) ? nb : m_b);
      check("dk0",  o_delta_k0, (n >= 3) ? ndk0 : m_dk0);
      check("dk1",  o_delta_k1, (n >= 4) ? ndk1 : m_dk1);
    end
    i_start = 1'b0;
    m_w0 = nw0; m_w1 = nw1; m_b = nb; m_dk0 = ndk0; m_dk1 = ndk1;
  endtask

  initial begin
    logic [31:0] nw0, nw1, nb, ndk0, ndk1;
    rst_n = 1'b0; i_load = 1'b0; i_start = 1'b0;
    i_w0_init = '0; i_w1_init = '0; i_bias_init = '0;
    i_k0 = '0; i_k1 = '0; i_a = '0; i_delta_in = '0; i_lr = '0;
    repeat (2) @(negedge clk);
    check_outputs("rst");
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_done", {31'b0, o_done}, 32'd0);
    rst_n = 1'b1;

    do_load(HLF, HLF, 32'h0);
    run_step(ONE, 32'h0, HLF, ONE, ONE, -1, 1'b0, 1'b0);
    check("nom_dk0",  o_delta_k0, 32'h0020_0000);
    check("nom_dk1",  o_delta_k1, 32'h0020_0000);
    check("nom_w0",   o_w0,       32'h0040_0000);
    check("nom_w1",   o_w1,       32'h0080_0000);
    check("nom_bias", o_bias,     32'hFFC0_0000);

    run_step($urandom, $urandom, 32'h0, $urandom, $urandom, -1, 1'b0, 1'b0);
    check("zd_dk0", o_delta_k0, 32'h0);
    check("zd_w0",  o_w0,       32'h0040_0000);

    do_load(ONE, ONE, 32'h0);
    run_step(32'h0, 32'h0, HLF, 32'hFFFF_FFFF, ONE, -1, 1'b0, 1'b0);
    check("floor_dk0", o_delta_k0, 32'hFFFF_FFFF);

    do_load(32'h7FFF_FFFF, 32'h0, 32'h0);
    run_step(ONE, 32'h0, HLF, 32'hFF00_0000, ONE, -1, 1'b0, 1'b0);
`ifdef PERCEPTRON_BP_SAT_EN
    check("ovf_w0", o_w0, 32'h7FFF_FFFF);
`else
    check("ovf_w0", o_w0, 32'h803F_FFFF);
`endif

    do_load($urandom, $urandom, $urandom);
    for (int i = 0; i < 4; i++) begin
      run_step($urandom, $urandom, $urandom_range(32'h0100_0000, 0), $urandom, $urandom, -1, i == 2, 1'b0);
    end

    // Start held high: one full step, then a second accept at E11 with the same inputs.
    run_step(HLF, ONE, 32'h0040_0000, ONE, HLF, -1, 1'b0, 1'b1);
    model_step(HLF, ONE, 32'h0040_0000, ONE, HLF, nw0, nw1, nb, ndk0, ndk1);
    m_w0 = nw0; m_w1 = nw1; m_b = nb; m_dk0 = ndk0; m_dk1 = ndk1;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      check("hold_done", {31'b0, o_done}, {31'b0, n == 10});
      check("hold_busy", {31'b0, o_busy}, {31'b0, n <= 10});
    end
    check_outputs("hold");

    @(negedge clk);
    i_load = 1'b1; i_start = 1'b1;
    i_w0_init = $urandom; i_w1_init = $urandom; i_bias_init = $urandom;
    m_w0 = i_w0_init; m_w1 = i_w1_init; m_b = i_bias_init;
    @(negedge clk);
    i_load = 1'b0; i_start = 1'b0;
    check("ldst_busy", {31'b0, o_busy}, 32'd0);
    check_outputs("ldst");
    @(negedge clk);
    check("ldst_busy2", {31'b0, o_busy}, 32'd0);

    run_step($urandom, $urandom, $urandom, $urandom, $urandom, 6, 1'b0, 1'b0);
    do_load($urandom, $urandom, $urandom);
    run_step($urandom, $urandom, $urandom, $urandom, $urandom, -1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
